// File: rtl/mesi_isc_breq_arb.sv
// Round-robin arbiter from the four per-CPU breq FIFOs into the broadcast FIFO,
// with an in-flight table that holds back heads whose line is still being broadcast.
module mesi_isc_breq_arb #(
    parameter int ADDR_WIDTH       = 32,
    parameter int BROAD_TYPE_WIDTH = 2,
    parameter int BROAD_ID_WIDTH   = 7,
    parameter int INFLIGHT_DEPTH   = 4,
    parameter int LINE_LSB         = 0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [3:0]                           fifo_status_empty_array_i,
    input  logic [4*ADDR_WIDTH-1:0]              broad_addr_array_i,
    input  logic [4*BROAD_TYPE_WIDTH-1:0]        broad_type_array_i,
    input  logic [4*BROAD_ID_WIDTH-1:0]          broad_id_array_i,
    input  logic                                 broad_fifo_status_full_i,
    input  logic                                 broad_done_i,
    input  logic [1:0]                           broad_done_cpu_id_i,
    input  logic [BROAD_ID_WIDTH-1:0]            broad_done_id_i,
    output logic [3:0]                           fifo_rd_array_o,
    output logic                                 broad_fifo_wr_o,
    output logic [ADDR_WIDTH-1:0]                broad_addr_o,
    output logic [BROAD_TYPE_WIDTH-1:0]          broad_type_o,
    output logic [1:0]                           broad_cpu_id_o,
    output logic [BROAD_ID_WIDTH-1:0]            broad_id_o,
    output logic [$clog2(INFLIGHT_DEPTH+1)-1:0]  inflight_count_o,
    output logic                                 inflight_full_o,
    output logic                                 done_err_o
);
    localparam int CW = $clog2(INFLIGHT_DEPTH + 1);

    logic [1:0]                  ptr_r;
    logic [3:0]                  cool_r;
    logic [INFLIGHT_DEPTH-1:0]   valid_r;
    logic [1:0]                  ent_cpu_r  [INFLIGHT_DEPTH];
    logic [BROAD_ID_WIDTH-1:0]   ent_id_r   [INFLIGHT_DEPTH];
    logic [ADDR_WIDTH-1:0]       ent_addr_r [INFLIGHT_DEPTH];
    logic [CW-1:0]               count_r;
    logic                        err_r;

    logic [ADDR_WIDTH-1:0]       head_addr_s [4];
    logic [BROAD_TYPE_WIDTH-1:0] head_type_s [4];
    logic [BROAD_ID_WIDTH-1:0]   head_id_s   [4];
    logic [3:0]                  conflict_s;
    logic [3:0]                  eligible_s;
    logic                        full_s;
    logic                        grant_s;
    logic                        found_s;
    logic [1:0]                  sel_s;
    logic [1:0]                  idx_s;
    logic [INFLIGHT_DEPTH-1:0]   match_s;
    logic [INFLIGHT_DEPTH-1:0]   free_oh_s;
    logic [CW-1:0]               clr_cnt_s;

    function automatic logic [CW-1:0] count_ones(input logic [INFLIGHT_DEPTH-1:0] v);
        logic [CW-1:0] n;
        n = '0;
        for (int e = 0; e < INFLIGHT_DEPTH; e++) begin
            n = n + CW'(v[e]);
        end
        return n;
    endfunction

    // Unpack the flattened per-CPU head fields.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            head_addr_s[i] = broad_addr_array_i[i*ADDR_WIDTH +: ADDR_WIDTH];
            head_type_s[i] = broad_type_array_i[i*BROAD_TYPE_WIDTH +: BROAD_TYPE_WIDTH];
            head_id_s[i]   = broad_id_array_i[i*BROAD_ID_WIDTH +: BROAD_ID_WIDTH];
        end
    end

    // A head conflicts when its line is still held by a valid in-flight entry.
    always_comb begin
        conflict_s = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            for (int e = 0; e < INFLIGHT_DEPTH; e++) begin
                conflict_s[i] = conflict_s[i] | (valid_r[e] &&
                    (ent_addr_r[e][ADDR_WIDTH-1:LINE_LSB] == head_addr_s[i][ADDR_WIDTH-1:LINE_LSB]));
            end
        end
    end

    assign eligible_s = ~fifo_status_empty_array_i & ~cool_r & ~conflict_s;
    assign full_s     = (count_r == CW'(INFLIGHT_DEPTH));
    assign grant_s    = (|eligible_s) && !broad_fifo_status_full_i && !full_s && !rst;

    // Round-robin search starting just after the last granted CPU.
    always_comb begin
        found_s = 1'b0;
        sel_s   = ptr_r;
        idx_s   = ptr_r;
        for (int k = 0; k < 4; k++) begin
            idx_s = ptr_r + 2'(k + 1);
            if (!found_s && eligible_s[idx_s]) begin
                found_s = 1'b1;
                sel_s   = idx_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Pop and push are combinational in the decision cycle.
    always_comb begin
        fifo_rd_array_o = 4'b0000;
        broad_fifo_wr_o = 1'b0;
        broad_addr_o    = '0;
        broad_type_o    = '0;
        broad_cpu_id_o  = 2'b00;
        broad_id_o      = '0;
        if (grant_s) begin
            fifo_rd_array_o = 4'b0001 << sel_s;
            broad_fifo_wr_o = 1'b1;
            broad_addr_o    = head_addr_s[sel_s];
            broad_type_o    = head_type_s[sel_s];
            broad_cpu_id_o  = sel_s;
            broad_id_o      = head_id_s[sel_s];
        end else begin
            broad_fifo_wr_o = 1'b0;
        end
    end

    // Completion matching and lowest free slot for the next insert.
    always_comb begin
        for (int e = 0; e < INFLIGHT_DEPTH; e++) begin
            match_s[e] = broad_done_i && valid_r[e] &&
                         (ent_cpu_r[e] == broad_done_cpu_id_i) && (ent_id_r[e] == broad_done_id_i);
        end
        free_oh_s = ~valid_r & (valid_r + INFLIGHT_DEPTH'(1));
        clr_cnt_s = count_ones(match_s);
    end

    // Pointer, cooldown, in-flight table, count and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r   <= 2'd3;
            cool_r  <= 4'b0000;
            valid_r <= '0;
            count_r <= '0;
            err_r   <= 1'b0;
            for (int e = 0; e < INFLIGHT_DEPTH; e++) begin
                ent_cpu_r[e]  <= 2'b00;
                ent_id_r[e]   <= '0;
                ent_addr_r[e] <= '0;
            end
        end else begin
            if (grant_s) begin
                ptr_r  <= sel_s;
                cool_r <= 4'b0001 << sel_s;
            end else begin
                cool_r <= 4'b0000;
            end
            // Cleared slots are valid pre-edge and the insert slot is not, so they never collide.
            valid_r <= (valid_r & ~match_s) | (grant_s ? free_oh_s : '0);
            for (int e = 0; e < INFLIGHT_DEPTH; e++) begin
                if (grant_s && free_oh_s[e]) begin
                    ent_cpu_r[e]  <= sel_s;
                    ent_id_r[e]   <= head_id_s[sel_s];
                    ent_addr_r[e] <= head_addr_s[sel_s];
                end
            end
            count_r <= count_r + CW'(grant_s) - clr_cnt_s;
            if (broad_done_i && (match_s == '0)) begin
                err_r <= 1'b1;
            end
        end
    end

    assign inflight_count_o = count_r;
    assign inflight_full_o  = full_s;
    assign done_err_o       = err_r;

endmodule
